// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch unit
package if_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_id_reg.sv
// rtl/if_fetch_unit_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
  import if_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [31:0]        pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid
);

  // Flush wins over load so a redirect always leaves a bubble behind it.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      if_pc    <= 32'h0000_0000;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (load) begin
      if_pc    <= pc_in;
      if_instr <= instr_in;
      if_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, redirect/stall FSM and fetch counter
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [31:0]        branch_addr,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4;
  logic         load, flush;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= {RESET_PC[31:2], 2'b00};
      fetch_count <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (load && fetch_count != '1)
        fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  // Redirect beats stall beats advance; the boot cycle ignores both requests.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    flush      = 1'b0;
    case (state)
      S_BOOT: state_next = S_RUN;
      S_RUN, S_STALL: begin
        if (branch_taken) begin
          pc_next    = {branch_addr[31:2], 2'b00};
          flush      = 1'b1;
          state_next = S_RUN;
        end else if (freeze) begin
          state_next = S_STALL;
        end else begin
          pc_next    = pc_plus4;
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      default: state_next = S_BOOT;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .flush    (flush),
    .pc_in    (pc_plus4),
    .instr_in (imem_instr),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_valid (if_valid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, freeze, branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr, imem_instr, if_pc, if_instr;
  logic        if_valid;
  logic [15:0] fetch_count;
  logic [31:0] imem_addr4, imem_instr4, if_pc4, if_instr4;
  logic        if_valid4;
  logic [3:0]  fetch_count4;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_model(input logic [31:0] a);
    return (a == 32'h0) ? 32'hE3A0_0014 : {16'hC0DE, a[15:0]};
  endfunction

  assign imem_instr  = imem_model(imem_addr);
  assign imem_instr4 = imem_model(imem_addr4);

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .fetch_count(fetch_count)
  );

  if_fetch_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr4), .imem_instr(imem_instr4),
    .if_pc(if_pc4), .if_instr(if_instr4), .if_valid(if_valid4), .fetch_count(fetch_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_core(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                            input logic [31:0] instr, input logic v, input logic [31:0] fc);
    check({tag, "_pc"},    imem_addr, pc);
    check({tag, "_ifpc"},  if_pc, ipc);
    check({tag, "_instr"}, if_instr, instr);
    check({tag, "_valid"}, 32'(if_valid), 32'(v));
    check({tag, "_count"}, 32'(fetch_count), fc);
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0040;
    step(); step();
    check_core("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("reset_state", 32'(dut.state), 32'(S_BOOT));

    rst_n = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
    step();
    check_core("boot", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("boot_state", 32'(dut.state), 32'(S_RUN));
    step();
    check_core("first", 32'h4, 32'h4, 32'hE3A0_0014, 1'b1, 32'd1);
    step(); step();
    check_core("run4", 32'hC, 32'hC, 32'hC0DE_0008, 1'b1, 32'd3);
    step();
    check_core("pre_frz", 32'h10, 32'h10, 32'hC0DE_000C, 1'b1, 32'd4);

    freeze = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_core("frozen", 32'h10, 32'h10, 32'hC0DE_000C, 1'b1, 32'd4);
    check("frz_state", 32'(dut.state), 32'(S_STALL));
    freeze = 1'b0;
    step();
    check_core("unfrz", 32'h14, 32'h14, 32'hC0DE_0010, 1'b1, 32'd5);
    check("unfrz_state", 32'(dut.state), 32'(S_RUN));

    for (int i = 0; i < 4; i++) step();
    check("at24_pc", imem_addr, 32'h24);
    branch_taken = 1'b1; branch_addr = 32'h0000_0003;
    step();
    check_core("br", 32'h0, 32'h0, 32'h0, 1'b0, 32'd9);
    branch_taken = 1'b0;
    step();
    check_core("br_tgt", 32'h4, 32'h4, 32'hE3A0_0014, 1'b1, 32'd10);

    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0080;
    step();
    check_core("frzbr", 32'h80, 32'h0, 32'h0, 1'b0, 32'd10);
    check("frzbr_state", 32'(dut.state), 32'(S_RUN));

    freeze = 1'b0; branch_addr = 32'hFFFF_FFFF;
    step();
    check("top_pc", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step();
    check_core("wrap", 32'h0, 32'h0, 32'hC0DE_FFFC, 1'b1, 32'd11);

    freeze = 1'b1;
    step();
    rst_n = 1'b0; branch_taken = 1'b1; branch_addr = 32'h0000_0040;
    step();
    check_core("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("rst_mid_state", 32'(dut.state), 32'(S_BOOT));
    check("rst_mid_cnt4", 32'(fetch_count4), 32'd0);
    rst_n = 1'b1;
    step();
    check_core("boot_ign", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("boot_ign_state", 32'(dut.state), 32'(S_RUN));

    freeze = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("cnt4_14", 32'(fetch_count4), 32'd14);
    for (int i = 0; i < 6; i++) step();
    check("cnt4_sat", 32'(fetch_count4), 32'hF);
    check("cnt16_20", 32'(fetch_count), 32'd20);
    check("pc_20", imem_addr, 32'd80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
